// File: rtl/entropy_pkg.sv
// Shared constants for the entropy collector:
// register map, STATUS bit positions, corrector states.
package entropy_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_DIV    = 8'h01;
  localparam logic [7:0] ADDR_STATUS = 8'h10;
  localparam logic [7:0] ADDR_DATA   = 8'h11;
  localparam logic [7:0] ADDR_DIVRD  = 8'h12;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_ALARM   = 3;
  localparam int ST_FILL_LO = 4;

  typedef enum logic {
    VN_FIRST  = 1'b0,
    VN_SECOND = 1'b1
  } vn_state_e;

endpackage

// File: rtl/entropy_fifo.sv
// Word FIFO for conditioned entropy.
// push/pop/wdata in; rdata (head), full, empty, fill out.
module entropy_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [15:0]                 wdata,
  output logic [15:0]                 rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] fill
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full    = (fill_q == FW'(FIFO_DEPTH));
    empty   = (fill_q == '0);
    // A pop on empty does nothing; a full FIFO
    // accepts a push only when a pop frees a slot.
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    fill_d  = fill_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata;
      wptr_d = wptr_q + AW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fill_q <= fill_d;
      mem_q  <= mem_d;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign fill  = fill_q;

endmodule

// File: rtl/entropy_collector.sv
// Ring-oscillator conditioning: sync, XOR-fold, von Neumann,
// repetition health test, 16-bit packing, FIFO, register bus.
// Ports: clk/nreset, cs/we/addr/dwrite/dread bus,
// raw_p/raw_n oscillators, data_avail, health_alarm.
module entropy_collector
  import entropy_pkg::*;
#(
  parameter int SAMPLE_DIV = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int REP_LIMIT  = 32
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [15:0] dwrite,
  output logic [15:0] dread,
  input  logic [15:0] raw_p,
  input  logic [15:0] raw_n,
  output logic        data_avail,
  output logic        health_alarm
);

  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT);

  logic [15:0]   p_s1_q, p_s1_d, p_s2_q, p_s2_d;
  logic [15:0]   n_s1_q, n_s1_d, n_s2_q, n_s2_d;
  logic          enable_q, enable_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   cnt_q, cnt_d;
  vn_state_e     state_q, state_d;
  logic          stored_q, stored_d;
  logic [15:0]   sr_q, sr_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          prev_q, prev_d;
  logic          alarm_q, alarm_d;
  logic          ovf_q, ovf_d;

  logic          wr_ctrl, wr_div, rd_en;
  logic          clear, raw_bit, sample;
  logic          emit, word_done, push, pop;
  logic [15:0]   fifo_rdata, status;
  logic          full, empty;
  logic [FW-1:0] fill;

  entropy_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nreset(nreset),
    .push  (push),
    .pop   (pop),
    .wdata (sr_d),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  always_comb begin
    p_s1_d  = raw_p;
    p_s2_d  = p_s1_q;
    n_s1_d  = raw_n;
    n_s2_d  = n_s1_q;
    raw_bit = ^(p_s2_q ^ n_s2_q);

    wr_ctrl = cs & we & (addr == ADDR_CTRL);
    wr_div  = cs & we & (addr == ADDR_DIV);
    rd_en   = cs & ~we;
    clear   = wr_ctrl & dwrite[1];
    pop     = rd_en & (addr == ADDR_DATA);

    enable_d = wr_ctrl ? dwrite[0] : enable_q;
    div_d    = div_q;
    if (wr_div) begin
      div_d = (dwrite == '0) ? 16'd1 : dwrite;
    end

    // >= guards against DIV shrinking below a running count.
    sample = enable_q & (cnt_q >= div_q - 16'd1);
    if (!enable_q || sample) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    state_d   = state_q;
    stored_d  = stored_q;
    sr_d      = sr_q;
    bcnt_d    = bcnt_q;
    emit      = 1'b0;
    word_done = 1'b0;
    if (!enable_q) begin
      state_d = VN_FIRST;
      sr_d    = '0;
      bcnt_d  = '0;
    end else if (sample) begin
      unique case (state_q)
        VN_FIRST: begin
          stored_d = raw_bit;
          state_d  = VN_SECOND;
        end
        VN_SECOND: begin
          emit    = (raw_bit != stored_q);
          state_d = VN_FIRST;
        end
      endcase
    end
    if (emit) begin
      sr_d      = {stored_q, sr_q[15:1]};
      bcnt_d    = bcnt_q + 4'd1;
      word_done = (bcnt_q == 4'd15);
    end
    push = word_done & ~alarm_q;

    rep_d   = rep_q;
    prev_d  = prev_q;
    alarm_d = alarm_q;
    if (sample) begin
      prev_d = raw_bit;
      // Count 0 means no reference bit yet.
      if (rep_q == '0 || raw_bit != prev_q) begin
        rep_d = RW'(1);
      end else if (rep_q != REP_MAX) begin
        rep_d = rep_q + RW'(1);
      end
      if (rep_d == REP_MAX) begin
        alarm_d = 1'b1;
      end
    end

    ovf_d = ovf_q | (push & full & ~pop);

    if (clear) begin
      alarm_d = 1'b0;
      ovf_d   = 1'b0;
      rep_d   = '0;
      prev_d  = 1'b0;
    end

    status = '0;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF]   = ovf_q;
    status[ST_ALARM] = alarm_q;
    status[ST_FILL_LO +: 4] = 4'(fill);

    dread = '0;
    if (rd_en) begin
      unique case (1'b1)
        addr == ADDR_STATUS: dread = status;
        addr == ADDR_DATA:
          dread = empty ? 16'h0000 : fifo_rdata;
        addr == ADDR_DIVRD: dread = div_q;
        default: dread = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      p_s1_q   <= '0;
      p_s2_q   <= '0;
      n_s1_q   <= '0;
      n_s2_q   <= '0;
      enable_q <= 1'b0;
      div_q    <= 16'(SAMPLE_DIV);
      cnt_q    <= '0;
      state_q  <= VN_FIRST;
      stored_q <= 1'b0;
      sr_q     <= '0;
      bcnt_q   <= '0;
      rep_q    <= '0;
      prev_q   <= 1'b0;
      alarm_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      p_s1_q   <= p_s1_d;
      p_s2_q   <= p_s2_d;
      n_s1_q   <= n_s1_d;
      n_s2_q   <= n_s2_d;
      enable_q <= enable_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      stored_q <= stored_d;
      sr_q     <= sr_d;
      bcnt_q   <= bcnt_d;
      rep_q    <= rep_d;
      prev_q   <= prev_d;
      alarm_q  <= alarm_d;
      ovf_q    <= ovf_d;
    end
  end

  assign data_avail   = ~empty;
  assign health_alarm = alarm_q;

endmodule

// File: doc/entropy_collector.md
# entropy_collector

Downstream conditioning stage for the ring-oscillator entropy source. It samples the 16-bit `p` and `n` oscillator vectors and XOR-folds them to one raw bit per sample. It removes bias with a von Neumann corrector, runs a repetition-count health test, packs debiased bits into 16-bit words and buffers them in a small FIFO. Host access uses the same 16-bit `cs`/`we`/`addr` register bus as the entropy source.

## Interface
- `SAMPLE_DIV`, 8: reset value of the sample divider register.
- `FIFO_DEPTH`, 8: FIFO words; power of two, 2..16.
- `REP_LIMIT`, 32: identical consecutive raw samples that trip the alarm.

Reset is `nreset`: asynchronous, active-low. Clock is `clk`.

- `clk` in 1: clock.
- `nreset` in 1: asynchronous active-low reset.
- `cs` in 1: register select.
- `we` in 1: write enable; read when `cs & ~we`.
- `addr` in 8: register address.
- `dwrite` in 16: write data.
- `dread` out 16: read data, combinational.
- `raw_p` in 16: oscillator vector p, asynchronous to `clk`.
- `raw_n` in 16: oscillator vector n, asynchronous to `clk`.
- `data_avail` out 1: FIFO non-empty.
- `health_alarm` out 1: sticky repetition alarm.

## Operation
- **Registers (write):**
  - 0x00 CTRL: bit0 `enable`. Bit1 `clear`, write-1 pulse that clears alarm, overflow and the repetition counter.
  - 0x01 DIV[15:0]. A written value of 0 is stored as 1.
- **Registers (read):**
  - 0x10 STATUS = {8'h0, fill[3:0], alarm, overflow, empty, full}.
  - 0x11 DATA = FIFO head. A read pops one word per cycle. A read when empty returns 0x0000 and does not pop.
  - 0x12 DIV.
  - Any other address reads 0x0000.
- **Synchronisation:** `raw_p` and `raw_n` pass through a 2-flop synchroniser. The raw bit is `^(p_sync ^ n_sync)`.
- **Sampling:** the divider counts 0..DIV-1 while enabled. At the terminal count it issues a one-cycle `sample` strobe and wraps to 0.
- **Von Neumann corrector:** on each sample, the FSM moves between FIRST and SECOND.
  - FIRST: store the bit, go to SECOND.
  - SECOND: if the bit differs from the stored bit, emit the stored bit. Otherwise discard. Return to FIRST.
- **Packing:** each emitted bit shifts into a 16-bit register, LSB-first, new bit entering at bit 15 and shifting right. Bit count runs 0..15; on the 16th bit the word is pushed and the count wraps to 0.
- **Health test:** the repetition counter increments when a sampled raw bit equals the previous sampled raw bit. Otherwise it reloads to 1. When it reaches REP_LIMIT, `alarm` sets (sticky) and the counter saturates.
- **Behaviour while alarm is set:** sampling, the corrector and the health test keep running, but completed words are discarded rather than pushed.
- **FIFO push and pop:**
  - Push when full: word dropped, `overflow` sets (sticky).
  - Push and pop in the same cycle when full: both succeed and fill is unchanged.
  - Push and pop in the same cycle when empty: the read returns 0x0000 and the push succeeds.
- **Enable low:** the divider holds at 0, the FSM returns to FIRST, and the shift register and bit count clear. FIFO contents, alarm and overflow are retained.
- **Clear with simultaneous alarm trip:** if `clear` coincides with the cycle the alarm would set, clear wins that cycle.
- **Reset values:**
  - `dread` = 0 with `cs` low.
  - `data_avail` = 0, `health_alarm` = 0.
  - `enable` = 0, DIV = SAMPLE_DIV.
  - FIFO empty, FSM in FIRST.
  - Repetition counter = 0 and previous bit = 0. The first sample after reset or clear only loads the previous bit and sets the counter to 1.

## Timing
- `dread` is valid in the same cycle as `cs & ~we` and the address. The pop takes effect at the next clock edge.
- Register writes take effect at the clock edge where `cs & we`.
- Input-to-sample latency is 2 cycles of synchroniser plus up to DIV cycles.
- A word needs at least 32 samples, so with DIV=1 the first word arrives at least 32 cycles after enable.
- `data_avail` rises the cycle after the push edge.
- `health_alarm` is registered. It rises the cycle after the tripping sample.

## Structure
- Shared package `entropy_pkg` holds:
  - address constants: ADDR_CTRL 0x00, ADDR_DIV 0x01, ADDR_STATUS 0x10, ADDR_DATA 0x11, ADDR_DIVRD 0x12;
  - STATUS bit indices;
  - the corrector state encoding.
- One sub-module, `entropy_fifo`: synchronous FIFO with parameter FIFO_DEPTH.
  - Ports: `push`, `pop`, `wdata`, `rdata`, `full`, `empty`, `fill`.
  - Implements the same-cycle push/pop rules above.

## Test plan
- **Reset:** assert `nreset`=0 mid-operation. Required: STATUS=0x0002 (empty), DIV reads 8, `health_alarm`=0, `data_avail`=0.
- **Debias:** DIV=1, enable, drive the raw bit as the pattern 0,1 repeated 16 times. Required: one word 0x0000; `data_avail` rises; DATA read returns 0x0000; STATUS then shows empty.
- **Discard:** feed pairs 1,1 and 0,0 only. Required: no push after 256 samples. Then feed 1,0 sixteen times. Required: word 0xFFFF.
- **Health:** hold `raw_p`=`raw_n`=0 for 40 samples. Required: `health_alarm` rises after the 32nd sample; no words are pushed. Write CTRL=0x0003. Required: alarm clears.
- **Overflow:** fill 8 words without reading, then complete a 9th. Required: STATUS fill=8, full=1, overflow=1. Then drain 8 reads returning the words in FIFO order; a 9th read returns 0x0000.
- **Concurrent push/pop:** with FIFO full, time a DATA read on the same cycle as a push. Required: fill stays 8, overflow stays 0, no word lost.
